// File: rtl/regfile_sequencer_if.sv
// ============================================================================
// regfile_sequencer_if : instruction, load, store and register-file signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_sequencer_if;
  logic       instr_valid;
  logic [9:0] instr;
  logic       instr_ready;

  logic       data_valid;
  logic [9:0] data_in;
  logic       data_ready;

  logic       dout_valid;
  logic [9:0] dout;
  logic       dout_ready;

  logic [9:0] rf_D;
  logic       rf_ENW;
  logic [1:0] rf_WRA;
  logic       rf_ENR0;
  logic       rf_ENR1;
  logic [1:0] rf_RDA0;
  logic [1:0] rf_RDA1;
  logic [9:0] rf_Q0;
  logic [9:0] rf_Q1;

  logic       carry;
  logic       zero;
  logic       done;
  logic       illegal;

  // Sequencer side
  modport slave (
    input  instr_valid, instr, data_valid, data_in, dout_ready, rf_Q0, rf_Q1,
    output instr_ready, data_ready, dout_valid, dout,
           rf_D, rf_ENW, rf_WRA, rf_ENR0, rf_ENR1, rf_RDA0, rf_RDA1,
           carry, zero, done, illegal
  );

  // Processor / register-file side
  modport master (
    output instr_valid, instr, data_valid, data_in, dout_ready, rf_Q0, rf_Q1,
    input  instr_ready, data_ready, dout_valid, dout,
           rf_D, rf_ENW, rf_WRA, rf_ENR0, rf_ENR1, rf_RDA0, rf_RDA1,
           carry, zero, done, illegal
  );
endinterface

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// ============================================================================
// regfile_sequencer : instruction sequencer driving a 4x10-bit register file
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_sequencer (
  input  wire logic          CLKb,
  input  wire logic          Rstb,
  regfile_sequencer_if.slave bus
);

  localparam logic [3:0] c_OP_NOP   = 4'b0000;
  localparam logic [3:0] c_OP_LOAD  = 4'b0001;
  localparam logic [3:0] c_OP_COPY  = 4'b0010;
  localparam logic [3:0] c_OP_ADD   = 4'b0011;
  localparam logic [3:0] c_OP_SUB   = 4'b0100;
  localparam logic [3:0] c_OP_AND   = 4'b0101;
  localparam logic [3:0] c_OP_OR    = 4'b0110;
  localparam logic [3:0] c_OP_XOR   = 4'b0111;
  localparam logic [3:0] c_OP_SWAP  = 4'b1000;
  localparam logic [3:0] c_OP_STORE = 4'b1001;
  localparam logic [3:0] c_OP_ILL   = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAITD = 3'd2,
    S_WB1   = 3'd3,
    S_WB2   = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [3:0]  r_op;
  logic [1:0]  r_rx;
  logic [1:0]  r_ry;
  logic [9:0]  r_opa;
  logic [9:0]  r_opb;
  logic [9:0]  r_result;
  logic        r_carry;
  logic        r_zero;
  logic        r_done;
  logic        r_illegal;

  logic        w_accept;
  logic [3:0]  w_in_op;
  logic        w_in_nop;
  logic        w_in_ill;
  logic        w_is_alu;
  logic [10:0] w_sum;
  logic [9:0]  w_alu_res;
  logic        w_alu_c;
  logic        w_done_set;
  logic        w_unused;

  assign w_in_op  = bus.instr[9:6];
  assign w_in_nop = (w_in_op == c_OP_NOP);
  assign w_in_ill = (w_in_op >= c_OP_ILL);
  assign w_accept = (r_state == S_IDLE) && bus.instr_valid;
  assign w_is_alu = (r_op >= c_OP_ADD) && (r_op <= c_OP_XOR);
  assign w_unused = ^bus.instr[1:0];

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge CLKb or negedge Rstb) begin
    if (!Rstb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ------------------------------------------------------------------------
  // Next state and Moore register-file controls
  // ------------------------------------------------------------------------
  always_comb begin
    w_next         = r_state;
    bus.data_ready = 1'b0;
    bus.dout_valid = 1'b0;
    bus.dout       = 10'd0;
    bus.rf_D       = 10'd0;
    bus.rf_ENW     = 1'b0;
    bus.rf_WRA     = 2'd0;
    bus.rf_ENR0    = 1'b0;
    bus.rf_ENR1    = 1'b0;
    bus.rf_RDA0    = 2'd0;
    bus.rf_RDA1    = 2'd0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_in_nop || w_in_ill) begin
            w_next = S_IDLE;
          end else if (w_in_op == c_OP_LOAD) begin
            w_next = S_WAITD;
          end else begin
            w_next = S_READ;
          end
        end
      end
      S_READ: begin
        bus.rf_ENR0 = 1'b1;
        bus.rf_RDA0 = r_rx;
        bus.rf_ENR1 = 1'b1;
        bus.rf_RDA1 = r_ry;
        w_next      = (r_op == c_OP_STORE) ? S_OUT : S_WB1;
      end
      S_WAITD: begin
        bus.data_ready = 1'b1;
        if (bus.data_valid) begin
          w_next = S_WB1;
        end
      end
      S_WB1: begin
        bus.rf_ENW = 1'b1;
        bus.rf_WRA = r_rx;
        bus.rf_D   = r_result;
        w_next     = (r_op == c_OP_SWAP) ? S_WB2 : S_IDLE;
      end
      S_WB2: begin
        bus.rf_ENW = 1'b1;
        bus.rf_WRA = r_ry;
        bus.rf_D   = r_opa;
        w_next     = S_IDLE;
      end
      S_OUT: begin
        bus.dout_valid = 1'b1;
        bus.dout       = r_opa;
        if (bus.dout_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // ALU, evaluated on the live read-port data during READ
  // ------------------------------------------------------------------------
  assign w_sum = {1'b0, bus.rf_Q0} + {1'b0, bus.rf_Q1};

  always_comb begin
    w_alu_res = bus.rf_Q1;
    w_alu_c   = 1'b0;
    case (r_op)
      c_OP_ADD: begin
        w_alu_res = w_sum[9:0];
        w_alu_c   = w_sum[10];
      end
      c_OP_SUB: begin
        w_alu_res = bus.rf_Q0 - bus.rf_Q1;
        w_alu_c   = (bus.rf_Q0 >= bus.rf_Q1);
      end
      c_OP_AND: w_alu_res = bus.rf_Q0 & bus.rf_Q1;
      c_OP_OR:  w_alu_res = bus.rf_Q0 | bus.rf_Q1;
      c_OP_XOR: w_alu_res = bus.rf_Q0 ^ bus.rf_Q1;
      default:  w_alu_res = bus.rf_Q1;
    endcase
  end

  // Completion is the edge that returns to IDLE, or a NOP accept
  assign w_done_set = ((r_state != S_IDLE) && (w_next == S_IDLE)) ||
                      (w_accept && w_in_nop);

  // ------------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------------
  always_ff @(posedge CLKb or negedge Rstb) begin
    if (!Rstb) begin
      r_op      <= 4'd0;
      r_rx      <= 2'd0;
      r_ry      <= 2'd0;
      r_opa     <= 10'd0;
      r_opb     <= 10'd0;
      r_result  <= 10'd0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= w_done_set;
      r_illegal <= w_accept && w_in_ill;

      if (w_accept) begin
        r_op <= w_in_op;
        r_rx <= bus.instr[5:4];
        r_ry <= bus.instr[3:2];
      end

      if (r_state == S_READ) begin
        r_opa    <= bus.rf_Q0;
        r_opb    <= bus.rf_Q1;
        r_result <= w_alu_res;
        if (w_is_alu) begin
          r_carry <= w_alu_c;
          r_zero  <= (w_alu_res == 10'd0);
        end
      end

      if ((r_state == S_WAITD) && bus.data_valid) begin
        r_result <= bus.data_in;
      end
    end
  end

  assign bus.instr_ready = (r_state == S_IDLE) && Rstb;
  assign bus.carry       = r_carry;
  assign bus.zero        = r_zero;
  assign bus.done        = r_done;
  assign bus.illegal     = r_illegal;

endmodule

`default_nettype wire
